// File: rtl/psum_col_ofifo_pkg.sv
// Shared sizing for the psum output FIFO; defaults track mac_tile/mac_array.
package psum_col_ofifo_pkg;

  localparam int unsigned COL_DEF     = 8;
  localparam int unsigned PSUM_BW_DEF = 16;
  localparam int unsigned DEPTH_DEF   = 64;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_col_ofifo_if.sv
// Row-oriented bus between the systolic array bottom edge, the output FIFO and its consumer.
interface psum_col_ofifo_if #(
  parameter int unsigned COL     = 8,
  parameter int unsigned PSUM_BW = 16
);
  logic [COL*PSUM_BW-1:0] psum_in;
  logic [COL-1:0]         wr;
  logic                   rd;
  logic [COL*PSUM_BW-1:0] psum_out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_overflow;

  modport master (
    output psum_in, wr, rd,
    input  psum_out, o_valid, o_full, o_ready, o_overflow
  );

  modport slave (
    input  psum_in, wr, rd,
    output psum_out, o_valid, o_full, o_ready, o_overflow
  );
endinterface

// File: rtl/psum_col_ofifo_col_fifo.sv
// One column of the output FIFO: wrap-bit pointers, combinational read of the head entry.
module col_fifo
  import psum_col_ofifo_pkg::*;
#(
  parameter int unsigned PSUM_BW = PSUM_BW_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_i,
  input  logic               rd_i,
  input  logic [PSUM_BW-1:0] in_i,
  output logic [PSUM_BW-1:0] out_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]      wptr_q, wptr_d;
  logic [PW-1:0]      rptr_q, rptr_d;
  logic [PSUM_BW-1:0] mem_q [DEPTH];
  logic               rd_acc;
  logic               wr_acc;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  // A pop frees the head slot this cycle, so a full column may still accept a write.
  assign rd_acc = rd_i & ~empty_o;
  assign wr_acc = wr_i & (~full_o | rd_acc);

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, wr_acc};
    rptr_d = rptr_q + {{AW{1'b0}}, rd_acc};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[AW-1:0]] <= in_i;
  end

  assign out_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/psum_col_ofifo.sv
// Column-skew absorbing output FIFO: releases one aligned psum row once every column holds data.
module psum_col_ofifo
  import psum_col_ofifo_pkg::*;
#(
  parameter int unsigned COL     = COL_DEF,
  parameter int unsigned PSUM_BW = PSUM_BW_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  psum_col_ofifo_if.slave bus_io
);

  logic [COL-1:0]         empty;
  logic [COL-1:0]         full;
  logic [COL*PSUM_BW-1:0] row;
  logic [COL*PSUM_BW-1:0] out_q, out_d;
  logic                   ovf_q, ovf_d;
  logic                   valid;
  logic                   any_full;
  logic                   rd_fire;

  for (genvar c = 0; c < COL; c++) begin : g_col
    col_fifo #(
      .PSUM_BW (PSUM_BW),
      .DEPTH   (DEPTH)
    ) u_col (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (bus_io.wr[c]),
      .rd_i    (rd_fire),
      .in_i    (bus_io.psum_in[c*PSUM_BW +: PSUM_BW]),
      .out_o   (row[c*PSUM_BW +: PSUM_BW]),
      .empty_o (empty[c]),
      .full_o  (full[c])
    );
  end

  assign valid    = ~|empty;
  assign any_full = |full;
  assign rd_fire  = bus_io.rd & valid;

  // Drops only count when no pop is freeing a slot in the same cycle.
  always_comb begin
    out_d = out_q;
    ovf_d = ovf_q | (|(bus_io.wr & full & {COL{~rd_fire}}));
    if (rd_fire) out_d = row;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus_io.psum_out   = out_q;
  assign bus_io.o_valid    = valid;
  assign bus_io.o_full     = any_full;
  assign bus_io.o_ready    = ~any_full;
  assign bus_io.o_overflow = ovf_q;

endmodule

// File: tb/tb_psum_col_ofifo.sv
// Directed bench for psum_col_ofifo: per-column reference model plus a row scoreboard.
module tb_psum_col_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 64;
  localparam int RW    = COL * BW;

  logic clk;
  logic reset;

  psum_col_ofifo_if #(.COL(COL), .PSUM_BW(BW)) bus ();

  psum_col_ofifo #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec;
  int errs;

  logic [BW-1:0] mbuf [COL][DEPTH];
  int            mhead [COL];
  int            mcnt  [COL];
  logic          movf;
  logic [RW-1:0] mout;
  logic [RW-1:0] sb [$];

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rep(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  function automatic logic m_valid();
    logic v;
    v = 1'b1;
    for (int c = 0; c < COL; c++) if (mcnt[c] == 0) v = 1'b0;
    return v;
  endfunction

  function automatic logic m_full();
    logic f;
    f = 1'b0;
    for (int c = 0; c < COL; c++) if (mcnt[c] == DEPTH) f = 1'b1;
    return f;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COL; c++) begin
      mhead[c] = 0;
      mcnt[c]  = 0;
    end
    movf = 1'b0;
    mout = '0;
    sb.delete();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.wr      = '0;
    bus.rd      = 1'b0;
    bus.psum_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: update model from pre-edge state, drive, then check after the edge.
  task automatic cyc(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    logic          fire;
    logic [RW-1:0] exp_row;
    fire    = r && m_valid();
    exp_row = '0;
    if (fire) begin
      for (int c = 0; c < COL; c++) exp_row[c*BW +: BW] = mbuf[c][mhead[c]];
      sb.push_back(exp_row);
    end
    for (int c = 0; c < COL; c++) begin
      logic acc;
      acc = 1'b0;
      if (w[c]) begin
        if (mcnt[c] < DEPTH || fire) begin
          mbuf[c][(mhead[c] + mcnt[c]) % DEPTH] = d[c*BW +: BW];
          acc = 1'b1;
        end else begin
          movf = 1'b1;
        end
      end
      if (fire) mhead[c] = (mhead[c] + 1) % DEPTH;
      mcnt[c] = mcnt[c] + (acc ? 1 : 0) - (fire ? 1 : 0);
    end
    bus.wr      = w;
    bus.psum_in = d;
    bus.rd      = r;
    @(posedge clk);
    #1;
    bus.wr = '0;
    bus.rd = 1'b0;
    if (fire) mout = sb.pop_front();
    chk("out", bus.psum_out, mout);
    chk("o_valid", RW'(bus.o_valid), RW'(m_valid()));
    chk("o_full", RW'(bus.o_full), RW'(m_full()));
    chk("o_ready", RW'(bus.o_ready), RW'(!m_full()));
    chk("o_overflow", RW'(bus.o_overflow), RW'(movf));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out"}, bus.psum_out, '0);
    chk({tag, "_valid"}, RW'(bus.o_valid), RW'(1'b0));
    chk({tag, "_full"}, RW'(bus.o_full), RW'(1'b0));
    chk({tag, "_ready"}, RW'(bus.o_ready), RW'(1'b1));
    chk({tag, "_ovf"}, RW'(bus.o_overflow), RW'(1'b0));
  endtask

  initial begin
    logic [RW-1:0] exp_row;
    logic [RW-1:0] d;
    vec   = 0;
    errs  = 0;
    reset = 1'b1;
    bus.wr      = '0;
    bus.rd      = 1'b0;
    bus.psum_in = '0;

    // 1: reset and idle
    do_reset();
    chk_reset_state("rst");
    repeat (3) cyc('0, '0, 1'b0);
    chk_reset_state("idle");

    // 2: skewed column writes, then one aligned pop
    for (int c = 0; c < COL; c++) begin
      chk("skew_valid_low", RW'(bus.o_valid), RW'(1'b0));
      cyc(COL'(1) << c, rep(16'h0100 + 16'(c)), 1'b0);
    end
    chk("skew_valid_high", RW'(bus.o_valid), RW'(1'b1));
    cyc('0, '0, 1'b1);
    for (int c = 0; c < COL; c++) exp_row[c*BW +: BW] = 16'h0100 + 16'(c);
    chk("skew_row", bus.psum_out, exp_row);
    chk("skew_valid_drop", RW'(bus.o_valid), RW'(1'b0));

    // 3: fill, overflow on col 3, drain in order
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc('1, rep(16'(i)), 1'b0);
    chk("fill_full", RW'(bus.o_full), RW'(1'b1));
    chk("fill_ready", RW'(bus.o_ready), RW'(1'b0));
    cyc(8'h08, rep(16'hDEAD), 1'b0);
    chk("ovf_set", RW'(bus.o_overflow), RW'(1'b1));
    for (int i = 0; i < DEPTH; i++) begin
      cyc('0, '0, 1'b1);
      chk("drain_row", bus.psum_out, rep(16'(i)));
    end
    cyc('0, '0, 1'b1);
    chk("drain_no_extra", bus.psum_out, rep(16'(DEPTH - 1)));

    // 4: simultaneous write and pop on a full FIFO
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc('1, rep(16'(i)), 1'b0);
    cyc('1, rep(16'hBEEF), 1'b1);
    chk("wrrd_row0", bus.psum_out, rep(16'h0000));
    chk("wrrd_full", RW'(bus.o_full), RW'(1'b1));
    chk("wrrd_ovf", RW'(bus.o_overflow), RW'(1'b0));
    for (int i = 1; i <= DEPTH; i++) cyc('0, '0, 1'b1);
    chk("wrrd_beef", bus.psum_out, rep(16'hBEEF));

    // 5: pop attempt with column 7 still empty
    do_reset();
    cyc(8'h7F, rep(16'h0055), 1'b0);
    cyc('0, '0, 1'b1);
    chk("partial_out", bus.psum_out, '0);
    chk("partial_valid", RW'(bus.o_valid), RW'(1'b0));
    cyc(8'h80, rep(16'h0077), 1'b0);
    cyc('0, '0, 1'b1);
    exp_row = rep(16'h0055);
    exp_row[7*BW +: BW] = 16'h0077;
    chk("partial_row", bus.psum_out, exp_row);
    chk("partial_single", RW'(bus.o_valid), RW'(1'b0));

    // 6: wrap with random data, then reset mid-stream
    do_reset();
    for (int n = 0; n < 200; n++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      cyc('1, d, 1'b0);
      cyc('0, '0, 1'b1);
    end
    for (int n = 0; n < 40; n++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      cyc(COL'($urandom()), d, 1'($urandom()));
    end
    for (int n = 0; n < 3; n++) cyc('1, {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
    do_reset();
    chk_reset_state("midrst");
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc('1, d, 1'b0);
    cyc('0, '0, 1'b1);
    chk("midrst_new", bus.psum_out, d);
    chk("midrst_empty", RW'(bus.o_valid), RW'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
